// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-side and response signals of the shared-ALU arbiter.
// The slave modport is the arbiter's view; master is the issue/ALU/consumer side.
interface alu_share_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 6
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic [CTRL_W-1:0] req0_ctrl;
  logic [CTRL_W-1:0] req1_ctrl;
  logic              req0_branch_op;
  logic              req1_branch_op;
  logic [WIDTH-1:0]  req0_a;
  logic [WIDTH-1:0]  req0_b;
  logic [WIDTH-1:0]  req1_a;
  logic [WIDTH-1:0]  req1_b;

  logic              alu_branch_op;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_opA;
  logic [WIDTH-1:0]  alu_opB;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_branch;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [WIDTH-1:0]  rsp_result;
  logic              rsp_branch;

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_ctrl, req1_ctrl,
    input  req0_branch_op, req1_branch_op,
    input  req0_a, req0_b, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_branch_op, alu_ctrl, alu_opA, alu_opB,
    input  alu_result, alu_branch,
    output rsp_valid, rsp_id, rsp_result, rsp_branch,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req1_valid,
    output req0_ctrl, req1_ctrl,
    output req0_branch_op, req1_branch_op,
    output req0_a, req0_b, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_branch_op, alu_ctrl, alu_opA, alu_opB,
    output alu_result, alu_branch,
    input  rsp_valid, rsp_id, rsp_result, rsp_branch,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (id 0)
// and the branch/address unit (id 1); one op in flight, result returned with its id.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              alu_branch_op_q, alu_branch_op_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0]  alu_opa_q, alu_opa_d;
  logic [WIDTH-1:0]  alu_opb_q, alu_opb_d;
  logic              rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic              rsp_branch_q, rsp_branch_d;

  logic gnt0;
  logic gnt1;
  logic accept;
  logic capture;
  logic ready0;
  logic ready1;
  logic rsp_valid;

  // On contention the requester that did not win last time is favoured.
  always_comb begin
    gnt0 = bus.req0_valid && (!bus.req1_valid || last_q);
    gnt1 = bus.req1_valid && (!bus.req0_valid || !last_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt0 || gnt1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Readies are masked by reset_n so they read 0 while reset is held.
  always_comb begin
    ready0    = 1'b0;
    ready1    = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ready0 = reset_n && gnt0;
        ready1 = reset_n && gnt1;
        accept = gnt0 || gnt1;
      end
      EXEC:    capture   = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    last_d          = last_q;
    alu_branch_op_d = alu_branch_op_q;
    alu_ctrl_d      = alu_ctrl_q;
    alu_opa_d       = alu_opa_q;
    alu_opb_d       = alu_opb_q;
    rsp_id_d        = rsp_id_q;
    rsp_result_d    = rsp_result_q;
    rsp_branch_d    = rsp_branch_q;
    if (accept) begin
      last_d   = gnt1;
      rsp_id_d = gnt1;
      if (gnt1) begin
        alu_branch_op_d = bus.req1_branch_op;
        alu_ctrl_d      = bus.req1_ctrl;
        alu_opa_d       = bus.req1_a;
        alu_opb_d       = bus.req1_b;
      end else begin
        alu_branch_op_d = bus.req0_branch_op;
        alu_ctrl_d      = bus.req0_ctrl;
        alu_opa_d       = bus.req0_a;
        alu_opb_d       = bus.req0_b;
      end
    end
    // The ALU may raise branch for any compare; only branch ops report it.
    if (capture) begin
      rsp_result_d = bus.alu_result;
      rsp_branch_d = bus.alu_branch & alu_branch_op_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q          <= 1'b1;
      alu_branch_op_q <= 1'b0;
      alu_ctrl_q      <= '0;
      alu_opa_q       <= '0;
      alu_opb_q       <= '0;
      rsp_id_q        <= 1'b0;
      rsp_result_q    <= '0;
      rsp_branch_q    <= 1'b0;
    end else begin
      last_q          <= last_d;
      alu_branch_op_q <= alu_branch_op_d;
      alu_ctrl_q      <= alu_ctrl_d;
      alu_opa_q       <= alu_opa_d;
      alu_opb_q       <= alu_opb_d;
      rsp_id_q        <= rsp_id_d;
      rsp_result_q    <= rsp_result_d;
      rsp_branch_q    <= rsp_branch_d;
    end
  end

  assign bus.req0_ready    = ready0;
  assign bus.req1_ready    = ready1;
  assign bus.alu_branch_op = alu_branch_op_q;
  assign bus.alu_ctrl      = alu_ctrl_q;
  assign bus.alu_opA       = alu_opa_q;
  assign bus.alu_opB       = alu_opb_q;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_branch    = rsp_branch_q;

  a_ready_exclusive: assert property (@(posedge clock) disable iff (!reset_n)
    !(bus.req0_ready && bus.req1_ready));

  a_rsp_stable: assert property (@(posedge clock) disable iff (!reset_n)
    (bus.rsp_valid && !bus.rsp_ready) |=> (bus.rsp_valid && $stable(bus.rsp_result)
                                          && $stable(bus.rsp_id) && $stable(bus.rsp_branch)));

endmodule
